// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among N byte sources.
// A grant lasts a whole packet, a burst cap, or until the owner stalls.
module uart_tx_arbiter #(
    parameter int N            = 4,
    parameter int MAX_BURST    = 16,
    parameter int STALL_CYCLES = 1024
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ready,
    output logic [N-1:0]     grant,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_busy
);

    localparam int PW = $clog2(N);
    localparam int SW = $clog2(STALL_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]      burst_cnt_q, burst_cnt_d;
    logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            last_q, last_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic            cur_valid;
    logic            cur_last;
    logic [7:0]      cur_byte;
    logic            accept;

    // First requester after rr_ptr, wrapping around
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= N; i++) begin
            cand = PW'((int'(rr_ptr_q) + i) % N);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign cur_valid = req_valid[gidx_q];
    assign cur_last  = req_last[gidx_q];
    assign cur_byte  = req_data[{gidx_q, 3'b000} +: 8];
    assign accept    = (state_q == ARM) && cur_valid && !tx_busy;

    assign req_ready = accept ? grant_q : '0;
    assign grant     = grant_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;

    // Next-state logic for the grant/issue sequence
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        stall_cnt_d = stall_cnt_q;
        last_d      = last_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    gidx_d           = win_idx;
                    burst_cnt_d      = '0;
                    stall_cnt_d      = '0;
                    state_d          = ARM;
                end
            end
            ARM: begin
                if (accept) begin
                    tx_data_d   = cur_byte;
                    last_d      = cur_last;
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    stall_cnt_d = '0;
                    tx_valid_d  = 1'b1;
                    state_d     = ISSUE;
                end else if (!cur_valid) begin
                    if (stall_cnt_q == SW'(STALL_CYCLES - 1)) begin
                        grant_d  = '0;
                        rr_ptr_d = gidx_q;
                        state_d  = IDLE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end else begin
                    stall_cnt_d = '0;
                end
            end
            ISSUE: begin
                tx_valid_d = 1'b0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q || burst_cnt_q == 8'(MAX_BURST)) begin
                        grant_d  = '0;
                        rr_ptr_d = gidx_q;
                        state_d  = IDLE;
                    end else begin
                        state_d = ARM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= PW'(N - 1);
            burst_cnt_q <= '0;
            stall_cnt_q <= '0;
            last_q      <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            last_q      <= last_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple busy-flag TX model.
// Sources are byte queues popped on req_ready.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           sysclk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   drv_valid = '0;
    logic [N-1:0]   man_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           force_busy = 1'b0;

    int checks = 0;
    int errors = 0;
    int busy_len = 10;
    int busy_cnt = 0;

    logic [8:0]  srcq [N][$];
    logic [11:0] log_q [$];

    assign req_valid = drv_valid | man_valid;
    assign tx_busy   = (busy_cnt != 0) | force_busy;

    uart_tx_arbiter #(
        .N(N),
        .MAX_BURST(16),
        .STALL_CYCLES(8)
    ) dut (
        .sysclk(sysclk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .grant(grant),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_busy(tx_busy)
    );

    always #5 sysclk = ~sysclk;

    // Source queues, TX busy model, and input drive just after the edge
    always @(posedge sysclk) begin
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && srcq[i].size() > 0)
                void'(srcq[i].pop_front());
        end
        if (tx_valid)
            busy_cnt <= busy_len;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
        #1;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                drv_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = srcq[i][0][7:0];
                req_last[i]        = srcq[i][0][8];
            end else begin
                drv_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    // Record every transmitted byte with its owner
    always @(negedge sysclk) begin
        if (tx_valid)
            log_q.push_back({grant, tx_data});
    end

    function automatic bit queues_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++)
            if (srcq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        man_valid = '0;
        force_busy = 1'b0;
        for (int i = 0; i < N; i++) srcq[i].delete();
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (n < 2000 && !(queues_empty() && grant == '0 && !tx_busy)) begin
            @(negedge sysclk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s idle timeout got %0d cycles required <2000", name, n);
        end
        repeat (2) @(negedge sysclk);
    endtask

    task automatic wait_grant(string name);
        int n = 0;
        while (n < 50 && grant == '0) begin
            @(negedge sysclk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL %s grant timeout got %0d cycles required <50", name, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge sysclk);
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL rst_grant got %b exp 0000", grant);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_tx_valid got %b exp 0", tx_valid);
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_tx_data got %h exp 00", tx_data);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_req_ready got %b exp 0000", req_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_packet();
        logic [11:0] e [3];
        e[0] = {4'b0001, 8'h41};
        e[1] = {4'b0001, 8'h42};
        e[2] = {4'b0001, 8'h43};
        busy_len = 10;
        log_q.delete();
        srcq[0].push_back({1'b0, 8'h41});
        srcq[0].push_back({1'b0, 8'h42});
        srcq[0].push_back({1'b1, 8'h43});
        wait_grant("single");
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant got %b exp 0001", grant);
        end
        wait_idle("single");
        checks++;
        if (log_q.size() != 3) begin
            errors++;
            $display("FAIL single_count got %0d exp 3", log_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= log_q.size() || log_q[i] !== e[i]) begin
                errors++;
                $display("FAIL single_byte%0d got %h exp %h", i,
                         (i < log_q.size()) ? log_q[i] : 12'hxxx, e[i]);
            end
        end
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL single_release got %b exp 0000", grant);
        end
    endtask

    task automatic test_round_robin();
        logic [11:0] e [5];
        e[0] = {4'b0001, 8'h10};
        e[1] = {4'b0010, 8'h20};
        e[2] = {4'b0100, 8'h30};
        e[3] = {4'b1000, 8'h40};
        e[4] = {4'b0001, 8'h11};
        do_reset();
        busy_len = 3;
        srcq[0].push_back({1'b1, 8'h10});
        srcq[0].push_back({1'b1, 8'h11});
        srcq[1].push_back({1'b1, 8'h20});
        srcq[2].push_back({1'b1, 8'h30});
        srcq[3].push_back({1'b1, 8'h40});
        wait_idle("rr");
        checks++;
        if (log_q.size() != 5) begin
            errors++;
            $display("FAIL rr_count got %0d exp 5", log_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= log_q.size() || log_q[i] !== e[i]) begin
                errors++;
                $display("FAIL rr_entry%0d got %h exp %h", i,
                         (i < log_q.size()) ? log_q[i] : 12'hxxx, e[i]);
            end
        end
    endtask

    task automatic test_burst_cap();
        logic [11:0] e;
        do_reset();
        busy_len = 2;
        for (int b = 1; b <= 20; b++)
            srcq[1].push_back({1'b0, 8'(b)});
        srcq[2].push_back({1'b1, 8'hC0});
        wait_idle("burst");
        checks++;
        if (log_q.size() != 21) begin
            errors++;
            $display("FAIL burst_count got %0d exp 21", log_q.size());
        end
        for (int i = 0; i < 21; i++) begin
            if (i < 16)
                e = {4'b0010, 8'(i + 1)};
            else if (i == 16)
                e = {4'b0100, 8'hC0};
            else
                e = {4'b0010, 8'(i)};
            checks++;
            if (i >= log_q.size() || log_q[i] !== e) begin
                errors++;
                $display("FAIL burst_entry%0d got %h exp %h", i,
                         (i < log_q.size()) ? log_q[i] : 12'hxxx, e);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        busy_len = 3;
        @(negedge sysclk);
        man_valid = 4'b1000;
        @(posedge sysclk);
        #1;
        man_valid = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge sysclk);
            checks++;
            if (grant !== 4'b1000) begin
                errors++;
                $display("FAIL stall_hold%0d got %b exp 1000", k, grant);
            end
        end
        @(negedge sysclk);
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL stall_release got %b exp 0000", grant);
        end
        checks++;
        if (log_q.size() != 0) begin
            errors++;
            $display("FAIL stall_no_tx got %0d exp 0", log_q.size());
        end
        srcq[3].push_back({1'b1, 8'h33});
        srcq[0].push_back({1'b1, 8'h03});
        wait_idle("stall");
        checks++;
        if (log_q.size() < 2 || log_q[0] !== {4'b0001, 8'h03}) begin
            errors++;
            $display("FAIL stall_next_first got %h exp 103",
                     (log_q.size() > 0) ? log_q[0] : 12'hxxx);
        end
        checks++;
        if (log_q.size() < 2 || log_q[1] !== {4'b1000, 8'h33}) begin
            errors++;
            $display("FAIL stall_next_second got %h exp 833",
                     (log_q.size() > 1) ? log_q[1] : 12'hxxx);
        end
    endtask

    task automatic test_reset_mid_packet();
        int n = 0;
        logic [11:0] e [4];
        e[0] = {4'b0010, 8'hA1};
        e[1] = {4'b0001, 8'h0F};
        e[2] = {4'b0010, 8'hA2};
        e[3] = {4'b0010, 8'hA3};
        do_reset();
        busy_len = 10;
        srcq[1].push_back({1'b0, 8'hA1});
        srcq[1].push_back({1'b0, 8'hA2});
        srcq[1].push_back({1'b1, 8'hA3});
        while (n < 50 && !tx_busy) begin
            @(negedge sysclk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL rstmid_busy timeout got %0d exp <50", n);
        end
        @(negedge sysclk);
        srcq[0].push_back({1'b1, 8'h0F});
        rst = 1'b1;
        @(negedge sysclk);
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_grant got %b exp 0000", grant);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_tx_valid got %b exp 0", tx_valid);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_req_ready got %b exp 0000", req_ready);
        end
        rst = 1'b0;
        wait_idle("rstmid");
        checks++;
        if (log_q.size() != 4) begin
            errors++;
            $display("FAIL rstmid_count got %0d exp 4", log_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= log_q.size() || log_q[i] !== e[i]) begin
                errors++;
                $display("FAIL rstmid_entry%0d got %h exp %h", i,
                         (i < log_q.size()) ? log_q[i] : 12'hxxx, e[i]);
            end
        end
    endtask

    task automatic test_busy_at_grant();
        do_reset();
        busy_len = 3;
        force_busy = 1'b1;
        srcq[2].push_back({1'b1, 8'h5A});
        wait_grant("busyhi");
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL busyhi_grant got %b exp 0100", grant);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge sysclk);
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL busyhi_ready%0d got %b exp 0000", k, req_ready);
            end
        end
        force_busy = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL busyhi_accept got %b exp 0100", req_ready);
        end
        wait_idle("busyhi");
        checks++;
        if (log_q.size() != 1 || log_q[0] !== {4'b0100, 8'h5A}) begin
            errors++;
            $display("FAIL busyhi_tx got %0d entries first %h exp 1 entry 45a",
                     log_q.size(), (log_q.size() > 0) ? log_q[0] : 12'hxxx);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_burst_cap();
        test_stall();
        test_reset_mid_packet();
        test_busy_at_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got timeout exp finish");
        $fatal(1);
    end

endmodule
